// File: rtl/udp_stream_rx.sv
// udp_stream_rx: filters Ethernet/IPv4/UDP frames from a 64-bit MAC RX stream and re-aligns the payload to lane 0.
// Build option: define UDP_RX_IP_CSUM_EN to also require a valid IPv4 header checksum before accepting a frame.
//
// state     | meaning
// S_HDR     | collecting header beats 0..5 (beat_cnt), decision on beat 5
// S_PAYLOAD | forwarding payload; 6 bytes carried from each input beat to the next output beat
// S_FLUSH   | emitting the carried tail bytes after the input tlast beat
// S_DROP    | discarding the rest of a filtered frame
module udp_stream_rx #(
    parameter int C_S00_AXIS_TDATA_WIDTH = 64,
    parameter int C_M00_AXIS_TDATA_WIDTH = 64,
    parameter int C_AXIS_TKEEP_WIDTH     = 8
) (
    input  logic                              s00_axis_aclk,
    input  logic                              s00_axis_areset,
    input  logic                              s00_axis_tvalid,
    output logic                              s00_axis_tready,
    input  logic [C_S00_AXIS_TDATA_WIDTH-1:0] s00_axis_tdata,
    input  logic [C_AXIS_TKEEP_WIDTH-1:0]     s00_axis_tkeep,
    input  logic                              s00_axis_tlast,
    input  logic                              s00_axis_tuser,
    output logic                              m00_axis_tvalid,
    input  logic                              m00_axis_tready,
    output logic [C_M00_AXIS_TDATA_WIDTH-1:0] m00_axis_tdata,
    output logic [C_AXIS_TKEEP_WIDTH-1:0]     m00_axis_tkeep,
    output logic                              m00_axis_tlast,
    output logic                              m00_axis_tuser,
    input  logic [47:0]                       cfg_mac,
    input  logic [31:0]                       cfg_ip,
    input  logic [15:0]                       cfg_port,
    output logic [31:0]                       rx_good_count,
    output logic [31:0]                       rx_drop_count
);

    typedef enum logic [1:0] {S_HDR, S_PAYLOAD, S_FLUSH, S_DROP} state_t;

    state_t      state, state_nxt;
    logic [2:0]  beat_cnt, beat_nxt;
    logic [63:0] din;
    logic [47:0] carry;
    logic [7:0]  flush_keep;
    logic        flush_user;

    logic [47:0] mac_q;
    logic [15:0] etype_q;
    logic [7:0]  ver_q;
    logic [7:0]  proto_q;
    logic [31:0] ip_q;
    logic [15:0] port_q;
    logic        csum_ok;
    logic        hdr_ok;

    logic        out_free;
    logic        hdr_fire;
    logic        emit;
    logic [63:0] emit_data;
    logic [7:0]  emit_keep;
    logic        emit_last;
    logic        emit_user;
    logic        carry_ld;
    logic        flush_ld;
    logic        good_inc;
    logic        drop_inc;

    assign din = s00_axis_tdata;

`ifdef UDP_RX_IP_CSUM_EN
    // Ones' complement sum of bytes 14..33 folded per beat; a valid header sums to FFFF.
    logic [15:0] csum_acc;
    logic [3:0]  csum_mask;
    logic [19:0] csum_sum;
    logic [16:0] csum_fold;
    logic [15:0] csum_next;

    always_comb begin
        csum_mask = 4'b0000;
        case (beat_cnt)
            3'd1:    csum_mask = 4'b1000;
            3'd2:    csum_mask = 4'b1111;
            3'd3:    csum_mask = 4'b1111;
            3'd4:    csum_mask = 4'b0001;
            default: csum_mask = 4'b0000;
        endcase
        csum_sum = {4'h0, csum_acc};
        for (int i = 0; i < 4; i++) begin
            if (csum_mask[i]) csum_sum = csum_sum + {4'h0, din[16*i +: 8], din[16*i+8 +: 8]};
        end
        csum_fold = {1'b0, csum_sum[15:0]} + {13'h0, csum_sum[19:16]};
        csum_next = csum_fold[15:0] + {15'h0, csum_fold[16]};
    end

    always_ff @(posedge s00_axis_aclk) begin
        if (s00_axis_areset) begin
            csum_acc <= '0;
        end else if (hdr_fire) begin
            if (beat_cnt == 3'd0) csum_acc <= '0;
            else if (beat_cnt <= 3'd4) csum_acc <= csum_next;
        end
    end

    assign csum_ok = (csum_acc == 16'hFFFF);
`else
    assign csum_ok = 1'b1;
`endif

    assign hdr_ok = ((mac_q == cfg_mac) || (mac_q == 48'hFFFF_FFFF_FFFF)) &&
                    (etype_q == 16'h0800) && (ver_q == 8'h45) && (proto_q == 8'h11) &&
                    (ip_q == cfg_ip) && (port_q == cfg_port) && csum_ok;

    always_ff @(posedge s00_axis_aclk) begin
        if (s00_axis_areset) begin
            state    <= S_HDR;
            beat_cnt <= '0;
        end else begin
            state    <= state_nxt;
            beat_cnt <= beat_nxt;
        end
    end

    always_comb begin
        state_nxt       = state;
        beat_nxt        = beat_cnt;
        s00_axis_tready = 1'b0;
        out_free        = !m00_axis_tvalid || m00_axis_tready;
        hdr_fire        = 1'b0;
        emit            = 1'b0;
        emit_data       = '0;
        emit_keep       = '0;
        emit_last       = 1'b0;
        emit_user       = 1'b0;
        carry_ld        = 1'b0;
        flush_ld        = 1'b0;
        good_inc        = 1'b0;
        drop_inc        = 1'b0;
        case (state)
            S_HDR: begin
                s00_axis_tready = 1'b1;
                if (s00_axis_tvalid) begin
                    hdr_fire = 1'b1;
                    if (beat_cnt != 3'd5) begin
                        if (s00_axis_tlast) begin
                            drop_inc = 1'b1;
                            beat_nxt = '0;
                        end else begin
                            beat_nxt = beat_cnt + 3'd1;
                        end
                    end else begin
                        beat_nxt = '0;
                        if (!hdr_ok) begin
                            if (s00_axis_tlast) drop_inc = 1'b1;
                            else state_nxt = S_DROP;
                        end else begin
                            carry_ld = 1'b1;
                            if (!s00_axis_tlast) begin
                                state_nxt = S_PAYLOAD;
                            end else if (s00_axis_tkeep[7:2] != 6'h00) begin
                                flush_ld  = 1'b1;
                                state_nxt = S_FLUSH;
                            end else begin
                                good_inc = 1'b1;
                            end
                        end
                    end
                end
            end
            S_PAYLOAD: begin
                s00_axis_tready = out_free;
                if (s00_axis_tvalid && out_free) begin
                    emit      = 1'b1;
                    emit_data = {din[15:0], carry};
                    emit_keep = 8'hFF;
                    carry_ld  = 1'b1;
                    if (s00_axis_tlast) begin
                        if (s00_axis_tkeep[7:2] == 6'h00) begin
                            emit_keep = {s00_axis_tkeep[1:0], 6'h3F};
                            emit_last = 1'b1;
                            emit_user = s00_axis_tuser;
                            good_inc  = 1'b1;
                            state_nxt = S_HDR;
                        end else begin
                            flush_ld  = 1'b1;
                            state_nxt = S_FLUSH;
                        end
                    end
                end
            end
            S_FLUSH: begin
                if (out_free) begin
                    emit      = 1'b1;
                    emit_data = {16'h0000, carry};
                    emit_keep = flush_keep;
                    emit_last = 1'b1;
                    emit_user = flush_user;
                    good_inc  = 1'b1;
                    state_nxt = S_HDR;
                end
            end
            S_DROP: begin
                s00_axis_tready = 1'b1;
                if (s00_axis_tvalid && s00_axis_tlast) begin
                    drop_inc  = 1'b1;
                    state_nxt = S_HDR;
                end
            end
            default: state_nxt = S_HDR;
        endcase
    end

    always_ff @(posedge s00_axis_aclk) begin
        if (s00_axis_areset) begin
            m00_axis_tvalid <= 1'b0;
            m00_axis_tdata  <= '0;
            m00_axis_tkeep  <= '0;
            m00_axis_tlast  <= 1'b0;
            m00_axis_tuser  <= 1'b0;
            carry           <= '0;
            flush_keep      <= '0;
            flush_user      <= 1'b0;
            rx_good_count   <= '0;
            rx_drop_count   <= '0;
            mac_q           <= '0;
            etype_q         <= '0;
            ver_q           <= '0;
            proto_q         <= '0;
            ip_q            <= '0;
            port_q          <= '0;
        end else begin
            if (out_free) begin
                m00_axis_tvalid <= emit;
                if (emit) begin
                    m00_axis_tdata <= emit_data;
                    m00_axis_tkeep <= emit_keep;
                    m00_axis_tlast <= emit_last;
                    m00_axis_tuser <= emit_user;
                end
            end
            if (carry_ld) carry <= din[63:16];
            if (flush_ld) begin
                flush_keep <= {2'b00, s00_axis_tkeep[7:2]};
                flush_user <= s00_axis_tuser;
            end
            if (good_inc) rx_good_count <= rx_good_count + 32'd1;
            if (drop_inc) rx_drop_count <= rx_drop_count + 32'd1;
            // Header fields kept in wire order so they compare directly against cfg_*.
            if (hdr_fire) begin
                case (beat_cnt)
                    3'd0: mac_q <= {din[7:0], din[15:8], din[23:16], din[31:24], din[39:32], din[47:40]};
                    3'd1: begin
                        etype_q <= {din[39:32], din[47:40]};
                        ver_q   <= din[55:48];
                    end
                    3'd2: proto_q <= din[63:56];
                    3'd3: ip_q[31:16] <= {din[55:48], din[63:56]};
                    3'd4: begin
                        ip_q[15:0] <= {din[7:0], din[15:8]};
                        port_q     <= {din[39:32], din[47:40]};
                    end
                    default: ;
                endcase
            end
        end
    end

endmodule

// File: tb/tb_udp_stream_rx.sv
// Directed bench for udp_stream_rx: builds frames byte by byte, drives them beat by beat and
// checks output beats and counters against hand-computed values.
module tb_udp_stream_rx;

    logic        clk = 1'b0;
    logic        areset;
    logic        s_tvalid, s_tready, s_tlast, s_tuser;
    logic [63:0] s_tdata;
    logic [7:0]  s_tkeep;
    logic        m_tvalid, m_tready, m_tlast, m_tuser;
    logic [63:0] m_tdata;
    logic [7:0]  m_tkeep;
    logic [47:0] cfg_mac;
    logic [31:0] cfg_ip;
    logic [15:0] cfg_port;
    logic [31:0] good_cnt, drop_cnt;

    always #5 clk = ~clk;

    udp_stream_rx dut (
        .s00_axis_aclk   (clk),
        .s00_axis_areset (areset),
        .s00_axis_tvalid (s_tvalid),
        .s00_axis_tready (s_tready),
        .s00_axis_tdata  (s_tdata),
        .s00_axis_tkeep  (s_tkeep),
        .s00_axis_tlast  (s_tlast),
        .s00_axis_tuser  (s_tuser),
        .m00_axis_tvalid (m_tvalid),
        .m00_axis_tready (m_tready),
        .m00_axis_tdata  (m_tdata),
        .m00_axis_tkeep  (m_tkeep),
        .m00_axis_tlast  (m_tlast),
        .m00_axis_tuser  (m_tuser),
        .cfg_mac         (cfg_mac),
        .cfg_ip          (cfg_ip),
        .cfg_port        (cfg_port),
        .rx_good_count   (good_cnt),
        .rx_drop_count   (drop_cnt)
    );

    int          n_pass = 0;
    int          n_total = 0;
    logic [7:0]  fb[$];
    logic        frame_user = 1'b0;
    logic        sready_low;
    int          stall_g;
    logic [63:0] oq_data[$];
    logic [7:0]  oq_keep[$];
    logic        oq_last[$];
    logic        oq_user[$];

    always @(negedge clk) begin
        if (!areset && m_tvalid && m_tready) begin
            oq_data.push_back(m_tdata);
            oq_keep.push_back(m_tkeep);
            oq_last.push_back(m_tlast);
            oq_user.push_back(m_tuser);
        end
    end

    function automatic logic [63:0] od(int i);
        return (i < oq_data.size()) ? oq_data[i] : 64'hx;
    endfunction
    function automatic logic [7:0] okp(int i);
        return (i < oq_keep.size()) ? oq_keep[i] : 8'hx;
    endfunction
    function automatic logic ol(int i);
        return (i < oq_last.size()) ? oq_last[i] : 1'bx;
    endfunction
    function automatic logic ou(int i);
        return (i < oq_user.size()) ? oq_user[i] : 1'bx;
    endfunction

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_total++;
        assert (obs === exp) n_pass++;
        else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    endtask

    task automatic do_reset();
        areset   = 1'b1;
        s_tvalid = 1'b0;
        s_tlast  = 1'b0;
        s_tuser  = 1'b0;
        s_tdata  = '0;
        s_tkeep  = '0;
        repeat (3) @(posedge clk);
        #1 areset = 1'b0;
        oq_data.delete();
        oq_keep.delete();
        oq_last.delete();
        oq_user.delete();
    endtask

    task automatic build(input logic [47:0] dmac, input logic [15:0] dport, input int plen,
                         input logic [7:0] pstart);
        logic [15:0] tot, ulen;
        logic [19:0] sum;
        logic [16:0] f1;
        logic [15:0] cs;
        tot  = 16'(28 + plen);
        ulen = 16'(8 + plen);
        fb.delete();
        for (int i = 0; i < 6; i++) fb.push_back(dmac[47-8*i -: 8]);
        fb.push_back(8'h02); fb.push_back(8'h11); fb.push_back(8'h22);
        fb.push_back(8'h33); fb.push_back(8'h44); fb.push_back(8'h55);
        fb.push_back(8'h08); fb.push_back(8'h00); fb.push_back(8'h45); fb.push_back(8'h00);
        fb.push_back(tot[15:8]); fb.push_back(tot[7:0]);
        fb.push_back(8'h00); fb.push_back(8'h01); fb.push_back(8'h40); fb.push_back(8'h00);
        fb.push_back(8'h40); fb.push_back(8'h11); fb.push_back(8'h00); fb.push_back(8'h00);
        fb.push_back(8'hC0); fb.push_back(8'hA8); fb.push_back(8'h04); fb.push_back(8'h01);
        fb.push_back(8'hC0); fb.push_back(8'hA8); fb.push_back(8'h04); fb.push_back(8'h63);
        fb.push_back(8'h12); fb.push_back(8'h34);
        fb.push_back(dport[15:8]); fb.push_back(dport[7:0]);
        fb.push_back(ulen[15:8]); fb.push_back(ulen[7:0]);
        fb.push_back(8'h00); fb.push_back(8'h00);
        for (int i = 0; i < plen; i++) fb.push_back(8'(pstart + 8'(i)));
        sum = '0;
        for (int i = 14; i < 34; i += 2) sum = sum + {4'h0, fb[i], fb[i+1]};
        f1 = {1'b0, sum[15:0]} + {13'h0, sum[19:16]};
        cs = ~(f1[15:0] + {15'h0, f1[16]});
        fb[24] = cs[15:8];
        fb[25] = cs[7:0];
    endtask

    task automatic build_t1();
        build(48'hFFFF_FFFF_FFFF, 16'h303A, 6, 8'h00);
        fb[42] = 8'hBE; fb[43] = 8'hEF; fb[44] = 8'hAD;
        fb[45] = 8'hDE; fb[46] = 8'hCD; fb[47] = 8'hAB;
    endtask

    // Called and returns at posedge+1; tready sampled on the falling edge.
    task automatic send_frame(input int beat_limit, input bit with_last);
        int nb, idx;
        bit ok;
        nb = (fb.size() + 7) / 8;
        if (beat_limit > 0 && beat_limit < nb) nb = beat_limit;
        for (int b = 0; b < nb; b++) begin
            s_tdata = '0;
            s_tkeep = '0;
            for (int l = 0; l < 8; l++) begin
                idx = b * 8 + l;
                if (idx < fb.size()) begin
                    s_tdata[8*l +: 8] = fb[idx];
                    s_tkeep[l]        = 1'b1;
                end
            end
            s_tlast  = with_last && (b == nb - 1);
            s_tuser  = frame_user && s_tlast;
            s_tvalid = 1'b1;
            ok = 1'b0;
            for (int g = 0; g < 200; g++) begin
                @(negedge clk);
                if (s_tready) begin
                    ok = 1'b1;
                    break;
                end
                sready_low = 1'b1;
                @(posedge clk);
                #1;
            end
            if (!ok) begin
                n_total++;
                $error("FAIL send_timeout: beat %0d not accepted, required tready within 200 cycles", b);
                s_tvalid = 1'b0;
                return;
            end
            @(posedge clk);
            #1;
        end
        s_tvalid = 1'b0;
        s_tlast  = 1'b0;
        s_tuser  = 1'b0;
    endtask

    task automatic settle();
        repeat (8) @(posedge clk);
        #1;
    endtask

    initial begin
        cfg_mac    = 48'h02_00_00_00_00_01;
        cfg_ip     = 32'hC0A80463;
        cfg_port   = 16'h303A;
        m_tready   = 1'b1;
        sready_low = 1'b0;
        do_reset();

        chk("rst_tvalid", m_tvalid, 1'b0);
        chk("rst_tdata", m_tdata, 64'h0);
        chk("rst_tkeep", m_tkeep, 8'h00);
        chk("rst_tlast", m_tlast, 1'b0);
        chk("rst_tuser", m_tuser, 1'b0);
        chk("rst_good", good_cnt, 32'd0);
        chk("rst_drop", drop_cnt, 32'd0);
        chk("rst_sready", s_tready, 1'b1);

        // 6-byte payload: whole payload lives in beat 5 and leaves through the flush path
        build_t1();
        send_frame(0, 1'b1);
        settle();
        chk("t1_nbeats", oq_data.size(), 1);
        chk("t1_data", od(0), 64'h0000ABCDDEADEFBE);
        chk("t1_keep", okp(0), 8'h3F);
        chk("t1_last", ol(0), 1'b1);
        chk("t1_user", ou(0), 1'b0);
        chk("t1_good", good_cnt, 32'd1);
        chk("t1_drop", drop_cnt, 32'd0);

        // wrong destination port
        do_reset();
        build(48'hFFFF_FFFF_FFFF, 16'h3039, 6, 8'h00);
        sready_low = 1'b0;
        send_frame(0, 1'b1);
        settle();
        chk("t2_nbeats", oq_data.size(), 0);
        chk("t2_drop", drop_cnt, 32'd1);
        chk("t2_good", good_cnt, 32'd0);
        chk("t2_sready_low", sready_low, 1'b0);

        // 16-byte payload to unicast MAC with 3-cycle output stall on the first beat
        do_reset();
        build(48'h02_00_00_00_00_01, 16'h303A, 16, 8'h00);
        fork
            send_frame(0, 1'b1);
            begin
                stall_g = 0;
                while (!m_tvalid && stall_g < 100) begin
                    @(posedge clk);
                    #1;
                    stall_g++;
                end
                m_tready = 1'b0;
                repeat (3) begin
                    @(posedge clk);
                    #1;
                    chk("t3_stall_valid", m_tvalid, 1'b1);
                    chk("t3_stall_data", m_tdata, 64'h0706050403020100);
                end
                m_tready = 1'b1;
            end
        join
        settle();
        chk("t3_nbeats", oq_data.size(), 2);
        chk("t3_d0", od(0), 64'h0706050403020100);
        chk("t3_k0", okp(0), 8'hFF);
        chk("t3_l0", ol(0), 1'b0);
        chk("t3_d1", od(1), 64'h0F0E0D0C0B0A0908);
        chk("t3_k1", okp(1), 8'hFF);
        chk("t3_l1", ol(1), 1'b1);
        chk("t3_good", good_cnt, 32'd1);

        // runt (tlast on beat 3) followed immediately by a good frame
        do_reset();
        build_t1();
        send_frame(4, 1'b1);
        build_t1();
        send_frame(0, 1'b1);
        settle();
        chk("t4_drop", drop_cnt, 32'd1);
        chk("t4_good", good_cnt, 32'd1);
        chk("t4_nbeats", oq_data.size(), 1);
        chk("t4_data", od(0), 64'h0000ABCDDEADEFBE);
        chk("t4_keep", okp(0), 8'h3F);

        // 9-byte payload, MAC error flagged on the last input beat
        do_reset();
        build(48'hFFFF_FFFF_FFFF, 16'h303A, 9, 8'h00);
        frame_user = 1'b1;
        send_frame(0, 1'b1);
        frame_user = 1'b0;
        settle();
        chk("t5_nbeats", oq_data.size(), 2);
        chk("t5_d0", od(0), 64'h0706050403020100);
        chk("t5_k0", okp(0), 8'hFF);
        chk("t5_u0", ou(0), 1'b0);
        chk("t5_d1", od(1), 64'h0000000000000008);
        chk("t5_k1", okp(1), 8'h01);
        chk("t5_l1", ol(1), 1'b1);
        chk("t5_u1", ou(1), 1'b1);
        chk("t5_good", good_cnt, 32'd1);

        // 7-byte payload: one input byte on the tlast beat, no flush beat
        do_reset();
        build(48'hFFFF_FFFF_FFFF, 16'h303A, 7, 8'h10);
        send_frame(0, 1'b1);
        settle();
        chk("t6_nbeats", oq_data.size(), 1);
        chk("t6_data", od(0), 64'h0016151413121110);
        chk("t6_keep", okp(0), 8'h7F);
        chk("t6_last", ol(0), 1'b1);

        // zero-length payload then a MAC that is neither local nor broadcast
        do_reset();
        build(48'hFFFF_FFFF_FFFF, 16'h303A, 0, 8'h00);
        send_frame(0, 1'b1);
        build(48'h02_00_00_00_00_02, 16'h303A, 6, 8'h00);
        send_frame(0, 1'b1);
        settle();
        chk("t7_nbeats", oq_data.size(), 0);
        chk("t7_good", good_cnt, 32'd1);
        chk("t7_drop", drop_cnt, 32'd1);

        // IPv4 checksum: valid frame, then one with byte 24 corrupted
        do_reset();
        build_t1();
        send_frame(0, 1'b1);
        build_t1();
        fb[24] = fb[24] ^ 8'hFF;
        send_frame(0, 1'b1);
        settle();
`ifdef UDP_RX_IP_CSUM_EN
        chk("t8_good", good_cnt, 32'd1);
        chk("t8_drop", drop_cnt, 32'd1);
        chk("t8_nbeats", oq_data.size(), 1);
`else
        chk("t8_good", good_cnt, 32'd2);
        chk("t8_drop", drop_cnt, 32'd0);
        chk("t8_nbeats", oq_data.size(), 2);
`endif

        // reset in the middle of a header, then a clean frame
        do_reset();
        build_t1();
        send_frame(3, 1'b0);
        do_reset();
        build_t1();
        send_frame(0, 1'b1);
        settle();
        chk("t9_good", good_cnt, 32'd1);
        chk("t9_drop", drop_cnt, 32'd0);
        chk("t9_data", od(0), 64'h0000ABCDDEADEFBE);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
